wd279x_host_if: RTL
===================

WD279X_HOST_IF -- requirements
Module: wd279x_host_if

Interface
REQ-001 SHALL have ports: clk  in  1  system clock.
REQ-002 SHALL have: MRn  in  1  master reset, asynchronous, active-low.
REQ-003 SHALL have: addr  in  2  register select (0 cmd/status, 1 track, 2 sector, 3 data).
REQ-004 SHALL have: wr, rd  in  1 each  single-cycle host write and read strobes.
REQ-005 SHALL have: din  in  8 and dout  out  8  host data bus.
REQ-006 SHALL have: command  out  8 and command_start  out  1  latched command plus a one-cycle start pulse to the command engines.
REQ-007 SHALL have: cmd_done  in  1  engine completion pulse, and cmd_abort  out  1  abort pulse.
REQ-008 SHALL have: status_in  in  8  engine status; INTRQ_ACK  out  1  status-read pulse; busy  out  1.
REQ-009 SHALL have: track, sector  out  8 each; trk_load, sec_load  in  1 each, with trk_val, sec_val  in  8 each for engine updates.
REQ-010 SHALL have: data  out  8; data_load  in  1 with data_val  in  8; drq_set  in  1; DRQ  out  1.

Function
REQ-011 SHALL implement FSM IDLE, START, BUSY.
REQ-012 SHALL handle a command write (wr, addr 0) in IDLE as follows: latch din to command, enter START, and assert command_start for exactly one cycle on the next clk.
REQ-013 SHALL move from START to BUSY with busy=1, except for a Dx command, which returns to IDLE.
REQ-014 SHALL leave BUSY for IDLE on cmd_done, with busy=0 in the following cycle.
REQ-015 SHALL ignore non-Dx command writes while busy=1, leaving command unchanged.
REQ-016 SHALL accept a Dx command write in any state: latch it, pulse command_start, pulse cmd_abort for one cycle when it arrives in BUSY, then go to IDLE.
REQ-017 SHALL resolve a Dx write and cmd_done in the same cycle as a Dx write: cmd_abort is asserted.
REQ-018 SHALL ignore host writes to track and sector while busy=1; such writes SHALL take effect when idle.
REQ-019 SHALL give engine trk_load and sec_load priority over a host write in the same cycle.
REQ-020 SHALL always accept host data writes, and SHALL clear DRQ on a host data write or data read.
REQ-021 SHALL set DRQ on drq_set, with drq_set winning over a simultaneous clear; data_load SHALL update data.
REQ-022 SHALL drive dout combinationally from addr: addr 0 gives {status_in[7:1], busy}, and addr 1/2/3 give track, sector, data.
REQ-023 SHALL pulse INTRQ_ACK for one cycle on rd with addr 0.

Reset
REQ-024 SHALL asynchronously force the following while MRn=0: FSM IDLE, command 8'hD0, track 0, sector 1, data 0, DRQ 0, busy 0, and all pulses 0.
REQ-025 SHALL abandon any in-progress command on reset without asserting cmd_abort.

Configuration
REQ-026 SHALL treat the host bus as true polarity (WD2793/2797) when macro WD279X_INVERTED_BUS_EN is undefined.
REQ-027 SHALL, when WD279X_INVERTED_BUS_EN is defined, invert din on entry and dout on exit (WD2791/2795), so internal register values and engine ports are unaffected.

Verification
REQ-028 SHALL cover: release reset, then read addr 2 -> 8'h01; read addr 0 -> bit0=0.
REQ-029 SHALL cover: write 8'h08 to addr 0 -> command_start one cycle later, busy=1; then cmd_done -> busy=0 one cycle later.
REQ-030 SHALL cover: while busy, write 8'h58 to addr 0 -> command stays 8'h08, no command_start; then write 8'hD0 -> command_start, cmd_abort, busy=0.
REQ-031 SHALL cover: while busy, write 8'h22 to addr 1 -> track unchanged; same write when idle -> track=8'h22.
REQ-032 SHALL cover: drq_set with data_load val 8'hA5 -> DRQ=1; read addr 3 -> dout=8'hA5, DRQ=0 next cycle.
REQ-033 SHALL cover: with WD279X_INVERTED_BUS_EN defined, write din=8'hFE to addr 2 -> sector=8'h01; read addr 2 -> dout=8'hFE.

Source files
------------

// File: rtl/wd279x_host_if.sv
// WD279x host register interface: command/track/sector/data registers, command FSM, DRQ and status readback.
// Latency: register writes and pulses take effect one clk after the strobe; dout is combinational from addr.
// Backpressure: none; strobes are never stalled. Non-Dx command writes and track/sector writes are dropped while busy.
// Optional build macro WD279X_INVERTED_BUS_EN selects an inverted host data bus (WD2791/2795).
module wd279x_host_if (
   input  logic       clk,
   input  logic       MRn,
   input  logic [1:0] addr,
   input  logic       wr,
   input  logic       rd,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [7:0] command,
   output logic       command_start,
   input  logic       cmd_done,
   output logic       cmd_abort,
   input  logic [7:0] status_in,
   output logic       INTRQ_ACK,
   output logic       busy,
   output logic [7:0] track,
   output logic [7:0] sector,
   input  logic       trk_load,
   input  logic       sec_load,
   input  logic [7:0] trk_val,
   input  logic [7:0] sec_val,
   output logic [7:0] data,
   input  logic       data_load,
   input  logic [7:0] data_val,
   input  logic       drq_set,
   output logic       DRQ
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;

   logic [1:0] state;
   logic [7:0] din_i;
   logic [7:0] dout_i;
   logic       cmd_wr;
   logic       din_dx;
   logic       cmd_accept;
   logic       status_unused;

   // Bus polarity is handled only at the pins so registers and engine ports stay true-polarity.
`ifdef WD279X_INVERTED_BUS_EN
   assign din_i = ~din;
   assign dout  = ~dout_i;
`else
   assign din_i = din;
   assign dout  = dout_i;
`endif

   // Status bit 0 is replaced by the local busy flag on readback.
   assign status_unused = status_in[0];

   assign cmd_wr     = wr && (addr == 2'd0);
   assign din_dx     = (din_i[7:4] == 4'hD);
   // Force-interrupt (Dx) is always accepted; anything else only from IDLE.
   assign cmd_accept = cmd_wr && (din_dx || (state == ST_IDLE));

   // Command FSM: latch, start pulse, busy tracking and abort on a Dx arriving mid-command.
   always_ff @(posedge clk or negedge MRn) begin
      if (!MRn) begin
         state         <= ST_IDLE;
         command       <= 8'hD0;
         command_start <= 1'b0;
         cmd_abort     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         command_start <= 1'b0;
         cmd_abort     <= 1'b0;
         if (cmd_accept) begin
            command       <= din_i;
            command_start <= 1'b1;
            // Dx beats a same-cycle cmd_done, so the abort still fires in BUSY.
            cmd_abort     <= (state == ST_BUSY);
            if (din_dx && (state != ST_IDLE)) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end else begin
               state <= ST_START;
            end
         end else begin
            case (state)
               ST_IDLE: begin
               end
               ST_START: begin
                  if (command[7:4] == 4'hD) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_BUSY;
                     busy  <= 1'b1;
                  end
               end
               ST_BUSY: begin
                  if (cmd_done) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Track/sector registers: engine loads win, host writes are dropped while busy.
   always_ff @(posedge clk or negedge MRn) begin
      if (!MRn) begin
         track  <= 8'h00;
         sector <= 8'h01;
      end else begin
         if (trk_load) begin
            track <= trk_val;
         end else if (wr && (addr == 2'd1) && !busy) begin
            track <= din_i;
         end
         if (sec_load) begin
            sector <= sec_val;
         end else if (wr && (addr == 2'd2) && !busy) begin
            sector <= din_i;
         end
      end
   end

   // Data register and DRQ: any host data access clears DRQ unless the engine sets it that cycle.
   always_ff @(posedge clk or negedge MRn) begin
      if (!MRn) begin
         data <= 8'h00;
         DRQ  <= 1'b0;
      end else begin
         if (data_load) begin
            data <= data_val;
         end else if (wr && (addr == 2'd3)) begin
            data <= din_i;
         end
         if (drq_set) begin
            DRQ <= 1'b1;
         end else if ((wr || rd) && (addr == 2'd3)) begin
            DRQ <= 1'b0;
         end
      end
   end

   // Status read acknowledge pulse toward the interrupt logic.
   always_ff @(posedge clk or negedge MRn) begin
      if (!MRn) begin
         INTRQ_ACK <= 1'b0;
      end else begin
         INTRQ_ACK <= rd && (addr == 2'd0);
      end
   end

   // Readback mux, combinational from addr.
   always_comb begin
      dout_i = 8'h00;
      case (addr)
         2'd0:    dout_i = {status_in[7:1], busy};
         2'd1:    dout_i = track;
         2'd2:    dout_i = sector;
         default: dout_i = data;
      endcase
   end

endmodule
